// File: rtl/varredor_mux.sv
// rtl/varredor_mux.sv - 4:1 mux scan sequencer with per-channel dwell, capture and change flag
module varredor_mux #(
    parameter int WIDTH = 4,
    parameter int DWELL = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             modo_manual,
    input  logic [1:0]       sel_manual,
    input  logic [3:0]       mascara,
    input  logic [WIDTH-1:0] saida_mux,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] dado,
    output logic [1:0]       canal,
    output logic             valido,
    output logic             mudou,
    output logic             ocupado
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [1:0]       ptr, ptr_n;
    logic             modo_q, modo_n;
    logic [1:0]       sel_n;
    logic [WIDTH-1:0] dado_n;
    logic [1:0]       canal_n;
    logic             valido_n, mudou_n;
    logic             wr_ult;
    logic [WIDTH-1:0] ultimo [4];

    logic [2:0]       escolha_ini;
    logic [2:0]       escolha_prox;

    // Returns {found, channel}: first set mask bit scanning circularly from inicio, inclusive.
    function automatic logic [2:0] procura(input logic [3:0] m, input logic [1:0] inicio);
        logic [2:0] r;
        logic [1:0] c;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            c = inicio + 2'(i);
            if (m[c]) r = {1'b1, c};
        end
        return r;
    endfunction

    assign escolha_ini  = modo_manual ? {1'b1, sel_manual} : procura(mascara, ptr);
    assign escolha_prox = modo_manual ? {1'b1, sel_manual} : procura(mascara, sel + 2'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr    <= 2'd0;
            modo_q <= 1'b0;
            sel    <= 2'd0;
            dado   <= '0;
            canal  <= 2'd0;
            valido <= 1'b0;
            mudou  <= 1'b0;
            for (int i = 0; i < 4; i++) ultimo[i] <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ptr    <= ptr_n;
            modo_q <= modo_n;
            sel    <= sel_n;
            dado   <= dado_n;
            canal  <= canal_n;
            valido <= valido_n;
            mudou  <= mudou_n;
            if (wr_ult) ultimo[sel] <= saida_mux;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ptr_n    = ptr;
        modo_n   = modo_q;
        sel_n    = sel;
        dado_n   = dado;
        canal_n  = canal;
        valido_n = 1'b0;
        mudou_n  = 1'b0;
        wr_ult   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && escolha_ini[2]) begin
                    state_n = SETTLE;
                    sel_n   = escolha_ini[1:0];
                    cnt_n   = CNT_LOAD;
                    modo_n  = modo_manual;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (modo_manual != modo_q) begin
                    // Mode switch abandons the dwell and restarts on the new mode's channel.
                    modo_n = modo_manual;
                    if (escolha_ini[2]) begin
                        sel_n = escolha_ini[1:0];
                        cnt_n = CNT_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (modo_manual && (sel_manual != sel)) begin
                    sel_n = sel_manual;
                    cnt_n = CNT_LOAD;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    dado_n   = saida_mux;
                    canal_n  = sel;
                    valido_n = 1'b1;
                    mudou_n  = (saida_mux != ultimo[sel]);
                    wr_ult   = 1'b1;
                    ptr_n    = sel;
                    if (escolha_prox[2]) begin
                        sel_n = escolha_prox[1:0];
                        cnt_n = CNT_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ocupado = (state == SETTLE);
    end

endmodule

// File: tb/tb_varredor_mux.sv
// tb/tb_varredor_mux.sv - directed self-checking bench for varredor_mux
`timescale 1ns/1ps
module tb_varredor_mux;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       en1 = 1'b0;
    logic       modo_manual = 1'b0;
    logic [1:0] sel_manual = 2'd0;
    logic [3:0] mascara = 4'd0;
    logic [3:0] saida, saida1;
    logic [1:0] sel, canal, sel1, canal1;
    logic [3:0] dado, dado1;
    logic       valido, mudou, ocupado, valido1, mudou1, ocupado1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    // Mux model: channel 0..3 returns A=1, B=2, C=3, D=4.
    assign saida  = {2'b00, sel} + 4'd1;
    assign saida1 = {2'b00, sel1} + 4'd1;

    varredor_mux #(.WIDTH(4), .DWELL(3)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .modo_manual(modo_manual),
        .sel_manual(sel_manual), .mascara(mascara), .saida_mux(saida),
        .sel(sel), .dado(dado), .canal(canal), .valido(valido), .mudou(mudou), .ocupado(ocupado)
    );

    varredor_mux #(.WIDTH(4), .DWELL(1)) u_dut1 (
        .clock(clock), .reset(reset), .enable(en1), .modo_manual(modo_manual),
        .sel_manual(sel_manual), .mascara(mascara), .saida_mux(saida1),
        .sel(sel1), .dado(dado1), .canal(canal1), .valido(valido1), .mudou(mudou1), .ocupado(ocupado1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        en1    = 1'b0;
        tick();
        reset  = 1'b0;
    endtask

    task automatic cap(input string tag, input int exp_edges, input logic [3:0] ed,
                       input logic [1:0] ec, input logic em);
        int edges;
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!valido && edges < 20);
        chk({tag, ".valido"}, valido, 1);
        chk({tag, ".lat"}, edges, exp_edges);
        chk({tag, ".dado"}, dado, ed);
        chk({tag, ".canal"}, canal, ec);
        chk({tag, ".mudou"}, mudou, em);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv, no;

        repeat (2) begin
            enable      = 1'($urandom);
            en1         = 1'($urandom);
            modo_manual = 1'($urandom);
            sel_manual  = 2'($urandom);
            mascara     = 4'($urandom);
            tick();
        end
        chk("rst.sel", sel, 0);
        chk("rst.dado", dado, 0);
        chk("rst.canal", canal, 0);
        chk("rst.valido", valido, 0);
        chk("rst.mudou", mudou, 0);
        chk("rst.ocupado", ocupado, 0);
        chk("rst1.valido", valido1, 0);
        chk("rst1.ocupado", ocupado1, 0);

        // Full scan
        enable = 1'b0; en1 = 1'b0;
        modo_manual = 1'b0; sel_manual = 2'd0; mascara = 4'b1111;
        reset = 1'b0;
        enable = 1'b1;
        cap("scan0", 4, 4'd1, 2'd0, 1'b1);
        cap("scan1", 3, 4'd2, 2'd1, 1'b1);
        cap("scan2", 3, 4'd3, 2'd2, 1'b1);
        cap("scan3", 3, 4'd4, 2'd3, 1'b1);
        cap("scan4", 3, 4'd1, 2'd0, 1'b0);

        // Sparse mask
        do_reset();
        mascara = 4'b0101;
        enable  = 1'b1;
        cap("sp0", 4, 4'd1, 2'd0, 1'b1);
        cap("sp1", 3, 4'd3, 2'd2, 1'b1);
        cap("sp2", 3, 4'd1, 2'd0, 1'b0);
        cap("sp3", 3, 4'd3, 2'd2, 1'b0);

        // Empty mask, then single-bit mask
        do_reset();
        mascara = 4'b0000;
        enable  = 1'b1;
        nv = 0; no = 0;
        repeat (10) begin
            tick();
            nv += int'(valido);
            no += int'(ocupado);
        end
        chk("empty.valido_count", nv, 0);
        chk("empty.ocupado_count", no, 0);
        mascara = 4'b1000;
        cap("one0", 4, 4'd4, 2'd3, 1'b1);
        cap("one1", 3, 4'd4, 2'd3, 1'b0);
        cap("one2", 3, 4'd4, 2'd3, 1'b0);

        // Manual mode with a mid-dwell channel change
        do_reset();
        modo_manual = 1'b1;
        sel_manual  = 2'd2;
        mascara     = 4'b1111;
        enable      = 1'b1;
        cap("man0", 4, 4'd3, 2'd2, 1'b1);
        cap("man1", 3, 4'd3, 2'd2, 1'b0);
        tick();
        sel_manual = 2'd1;
        tick();
        chk("man_sw.sel", sel, 1);
        chk("man_sw.valido", valido, 0);
        cap("man_sw", 3, 4'd2, 2'd1, 1'b1);

        // Enable drop mid-dwell, resume, then reset mid-dwell
        do_reset();
        modo_manual = 1'b0;
        sel_manual  = 2'd0;
        mascara     = 4'b1111;
        enable      = 1'b1;
        cap("ab0", 4, 4'd1, 2'd0, 1'b1);
        tick();
        enable = 1'b0;
        tick();
        chk("ab.valido", valido, 0);
        chk("ab.ocupado", ocupado, 0);
        chk("ab.sel_hold", sel, 1);
        enable = 1'b1;
        cap("resume", 4, 4'd1, 2'd0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        chk("rmid.sel", sel, 0);
        chk("rmid.dado", dado, 0);
        chk("rmid.canal", canal, 0);
        chk("rmid.valido", valido, 0);
        chk("rmid.mudou", mudou, 0);
        chk("rmid.ocupado", ocupado, 0);
        reset  = 1'b0;
        enable = 1'b0;

        // DWELL=1 instance
        do_reset();
        mascara     = 4'b1111;
        modo_manual = 1'b0;
        en1         = 1'b1;
        tick();
        chk("d1.start_valido", valido1, 0);
        chk("d1.start_sel", sel1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("d1.valido", valido1, 1);
            chk("d1.canal", canal1, i % 4);
            chk("d1.dado", dado1, (i % 4) + 1);
        end
        en1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
